// File: rtl/stopwatch_counter_pkg.sv
// ============================================================================
// stopwatch_counter_pkg
// Shared state encoding and display constants for the SS.cc stopwatch.
// Revision: 1.0
// ============================================================================
`default_nettype none

package stopwatch_counter_pkg;

   localparam int BCD_W = 4;

   // Decimal point sits after the seconds-units digit (bin2).
   localparam logic [3:0] DP_PATTERN    = 4'b0100;
   localparam logic [3:0] EN_RESET      = 4'b0111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2,
      ST_LAP  = 2'd3
   } sw_state_t;

   function automatic logic [BCD_W-1:0] bcd_units(input int value);
      return BCD_W'(value % 10);
   endfunction

   function automatic logic [BCD_W-1:0] bcd_tens(input int value);
      return BCD_W'((value / 10) % 10);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_counter.sv
// ============================================================================
// bcd_digit_counter
// One BCD digit that counts 0..WRAP-1 on inc, with sync clear and carry out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_digit_counter
   import stopwatch_counter_pkg::*;
#(
   parameter int WRAP = 10
)
(
   input  logic             clk_1kHz,
   input  logic             rst_,
   input  logic             clr,
   input  logic             inc,
   output logic [BCD_W-1:0] digit,
   output logic             carry
);

   localparam logic [BCD_W-1:0] c_last = BCD_W'(WRAP - 1);
   localparam logic [BCD_W-1:0] c_one  = BCD_W'(1);

   logic [BCD_W-1:0] r_digit;

   always_ff @(posedge clk_1kHz) begin
      if (!rst_) begin
         r_digit <= '0;
      end else if (clr) begin
         r_digit <= '0;
      end else if (inc) begin
         r_digit <= (r_digit == c_last) ? '0 : r_digit + c_one;
      end
   end

   assign digit = r_digit;
   assign carry = inc & (r_digit == c_last);

endmodule

`default_nettype wire

// File: rtl/stopwatch_counter.sv
// ============================================================================
// stopwatch_counter
// BCD SS.cc stopwatch with start/stop, clear and lap; feeds the 4-digit display.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stopwatch_counter
   import stopwatch_counter_pkg::*;
#(
   parameter int TICKS_PER_CS = 10,
   parameter int SEC_WRAP     = 60
)
(
   input  logic       clk_1kHz,
   input  logic       rst_,
   input  logic       btn_start,
   input  logic       btn_clear,
   input  logic       btn_lap,
   output logic [3:0] bin0,
   output logic [3:0] bin1,
   output logic [3:0] bin2,
   output logic [3:0] bin3,
   output logic [3:0] dpin,
   output logic [3:0] en,
   output logic       running
);

   localparam int               c_pw             = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
   localparam logic [c_pw-1:0]  c_presc_last     = c_pw'(TICKS_PER_CS - 1);
   localparam logic [c_pw-1:0]  c_presc_one      = c_pw'(1);
   localparam int               c_sec_units_wrap = (SEC_WRAP < 10) ? SEC_WRAP : 10;
   localparam int               c_sec_tens_wrap  = ((SEC_WRAP - 1) / 10) + 1;
   localparam logic [BCD_W-1:0] c_sec_last_units = bcd_units(SEC_WRAP - 1);
   localparam logic [BCD_W-1:0] c_sec_last_tens  = bcd_tens(SEC_WRAP - 1);

   logic             r_start_prev, r_clear_prev, r_lap_prev;
   logic             w_start_ev, w_clear_ev, w_lap_ev;
   sw_state_t        r_state;
   logic             r_running;
   logic [c_pw-1:0]  r_presc;
   logic             w_counting, w_tick, w_freeze;
   logic [BCD_W-1:0] w_hu, w_ht, w_su, w_st;
   logic             w_hu_carry, w_ht_carry, w_su_carry, w_st_carry;
   logic             w_sec_roll, w_sec_clr;
   logic [BCD_W-1:0] w_bin3_next;
   logic [3:0]       r_bin0, r_bin1, r_bin2, r_bin3, r_dpin, r_en;

   always_ff @(posedge clk_1kHz) begin
      if (!rst_) begin
         r_start_prev <= 1'b0;
         r_clear_prev <= 1'b0;
         r_lap_prev   <= 1'b0;
      end else begin
         r_start_prev <= btn_start;
         r_clear_prev <= btn_clear;
         r_lap_prev   <= btn_lap;
      end
   end

   assign w_start_ev = btn_start & ~r_start_prev;
   assign w_clear_ev = btn_clear & ~r_clear_prev;
   assign w_lap_ev   = btn_lap   & ~r_lap_prev;

   // Branch order gives clear > start > lap within one cycle.
   always_ff @(posedge clk_1kHz) begin
      if (!rst_) begin
         r_state   <= ST_IDLE;
         r_running <= 1'b0;
      end else if (w_clear_ev) begin
         r_state   <= ST_IDLE;
         r_running <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_start_ev) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_start_ev) begin
                  r_state   <= ST_STOP;
                  r_running <= 1'b0;
               end else if (w_lap_ev) begin
                  r_state   <= ST_LAP;
                  r_running <= 1'b1;
               end
            end
            ST_STOP: begin
               if (w_start_ev) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end
            end
            ST_LAP: begin
               if (w_start_ev) begin
                  r_state   <= ST_STOP;
                  r_running <= 1'b0;
               end else if (w_lap_ev) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_running <= 1'b0;
            end
         endcase
      end
   end

   assign w_counting = (r_state == ST_RUN) || (r_state == ST_LAP);
   assign w_tick     = w_counting && (r_presc == c_presc_last);
   assign w_freeze   = (r_state == ST_LAP);

   always_ff @(posedge clk_1kHz) begin
      if (!rst_) begin
         r_presc <= '0;
      end else if (w_clear_ev) begin
         r_presc <= '0;
      end else if (w_counting) begin
         r_presc <= w_tick ? '0 : r_presc + c_presc_one;
      end
   end

   bcd_digit_counter #(.WRAP(10)) u_cs_units (
      .clk_1kHz (clk_1kHz),
      .rst_     (rst_),
      .clr      (w_clear_ev),
      .inc      (w_tick),
      .digit    (w_hu),
      .carry    (w_hu_carry)
   );

   bcd_digit_counter #(.WRAP(10)) u_cs_tens (
      .clk_1kHz (clk_1kHz),
      .rst_     (rst_),
      .clr      (w_clear_ev),
      .inc      (w_hu_carry),
      .digit    (w_ht),
      .carry    (w_ht_carry)
   );

   // Both seconds digits clear together when the next second would equal SEC_WRAP.
   assign w_sec_roll = w_st_carry
                     | (w_ht_carry && (w_su == c_sec_last_units) && (w_st == c_sec_last_tens));
   assign w_sec_clr  = w_clear_ev | w_sec_roll;

   bcd_digit_counter #(.WRAP(c_sec_units_wrap)) u_sec_units (
      .clk_1kHz (clk_1kHz),
      .rst_     (rst_),
      .clr      (w_sec_clr),
      .inc      (w_ht_carry),
      .digit    (w_su),
      .carry    (w_su_carry)
   );

   bcd_digit_counter #(.WRAP(c_sec_tens_wrap)) u_sec_tens (
      .clk_1kHz (clk_1kHz),
      .rst_     (rst_),
      .clr      (w_sec_clr),
      .inc      (w_su_carry),
      .digit    (w_st),
      .carry    (w_st_carry)
   );

   assign w_bin3_next = w_freeze ? r_bin3 : w_st;

   always_ff @(posedge clk_1kHz) begin
      if (!rst_) begin
         r_bin0 <= '0;
         r_bin1 <= '0;
         r_bin2 <= '0;
         r_bin3 <= '0;
         r_dpin <= DP_PATTERN;
         r_en   <= EN_RESET;
      end else begin
         if (!w_freeze) begin
            r_bin0 <= w_hu;
            r_bin1 <= w_ht;
            r_bin2 <= w_su;
            r_bin3 <= w_st;
         end
         r_dpin <= DP_PATTERN;
         r_en   <= {(w_bin3_next != '0), 3'b111};
      end
   end

   assign bin0    = r_bin0;
   assign bin1    = r_bin1;
   assign bin2    = r_bin2;
   assign bin3    = r_bin3;
   assign dpin    = r_dpin;
   assign en      = r_en;
   assign running = r_running;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
// ============================================================================
// tb_stopwatch_counter
// Scoreboard bench: integer-time reference model vs. stopwatch_counter outputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stopwatch_counter;

   localparam int TPC     = 10;
   localparam int SW      = 60;
   localparam int FULL_CS = SW * 100;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_STOP = 2;
   localparam int M_LAP  = 3;

   logic       clk_1kHz = 1'b0;
   logic       rst_;
   logic       btn_start, btn_clear, btn_lap;
   logic [3:0] bin0, bin1, bin2, bin3, dpin, en;
   logic       running;

   stopwatch_counter #(.TICKS_PER_CS(TPC), .SEC_WRAP(SW)) dut (
      .clk_1kHz  (clk_1kHz),
      .rst_      (rst_),
      .btn_start (btn_start),
      .btn_clear (btn_clear),
      .btn_lap   (btn_lap),
      .bin0      (bin0),
      .bin1      (bin1),
      .bin2      (bin2),
      .bin3      (bin3),
      .dpin      (dpin),
      .en        (en),
      .running   (running)
   );

   initial forever #5 clk_1kHz = ~clk_1kHz;

   typedef struct packed {
      logic [15:0] disp;
      logic [3:0]  dp;
      logic [3:0]  en;
      logic        run;
   } obs_t;

   obs_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model: elapsed time as a plain hundredths count plus cycle phase.
   int m_mode  = M_IDLE;
   int m_cs    = 0;
   int m_phase = 0;
   int m_disp  = 0;
   bit m_ps = 1'b0, m_pc = 1'b0, m_pl = 1'b0;

   task automatic model_step(input bit s, input bit c, input bit l, input bit rn);
      bit es, ec, el, live;
      if (!rn) begin
         m_mode = M_IDLE; m_cs = 0; m_phase = 0; m_disp = 0;
         m_ps = 1'b0; m_pc = 1'b0; m_pl = 1'b0;
      end else begin
         es   = s & !m_ps;
         ec   = c & !m_pc;
         el   = l & !m_pl;
         live = (m_mode == M_RUN) || (m_mode == M_LAP);
         if (m_mode != M_LAP) m_disp = m_cs;
         if (ec) begin
            m_cs = 0; m_phase = 0;
         end else if (live) begin
            m_phase++;
            if (m_phase == TPC) begin
               m_phase = 0;
               m_cs = (m_cs + 1) % FULL_CS;
            end
         end
         if (ec)                           m_mode = M_IDLE;
         else if (es)                      m_mode = live ? M_STOP : M_RUN;
         else if (el && m_mode == M_RUN)   m_mode = M_LAP;
         else if (el && m_mode == M_LAP)   m_mode = M_RUN;
         m_ps = s; m_pc = c; m_pl = l;
      end
   endtask

   function automatic obs_t model_view();
      obs_t o;
      o.disp = {4'(m_disp / 1000), 4'((m_disp / 100) % 10), 4'((m_disp / 10) % 10), 4'(m_disp % 10)};
      o.dp   = 4'b0100;
      o.en   = {(m_disp >= 1000), 3'b111};
      o.run  = (m_mode == M_RUN) || (m_mode == M_LAP);
      return o;
   endfunction

   task automatic cyc(input bit s, input bit c, input bit l, input bit rn);
      btn_start = s; btn_clear = c; btn_lap = l; rst_ = rn;
      model_step(s, c, l, rn);
      sb_q.push_back(model_view());
      @(negedge clk_1kHz);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic run_until(input int target);
      int guard;
      guard = 0;
      while (m_cs != target && guard < 70000) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b1);
         guard++;
      end
      if (m_cs != target) begin
         n_checks++;
         $display("FAIL run_until: count %0d after %0d cycles, wanted %0d", m_cs, guard, target);
      end
   endtask

   task automatic check_now(input string name, input logic [15:0] ed, input logic [3:0] een, input logic erun);
      n_checks++;
      if ({bin3, bin2, bin1, bin0} === ed && en === een && running === erun && dpin === 4'b0100)
         n_pass++;
      else
         $display("FAIL %s: actual disp=%h en=%b run=%b dp=%b, expected disp=%h en=%b run=%b dp=0100",
                  name, {bin3, bin2, bin1, bin0}, en, running, dpin, ed, een, erun);
   endtask

   initial begin : monitor
      obs_t e, a;
      forever begin
         @(posedge clk_1kHz);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = {bin3, bin2, bin1, bin0, dpin, en, running};
            n_checks++;
            if (a === e)
               n_pass++;
            else
               $display("FAIL scoreboard t=%0t: actual disp=%h dp=%b en=%b run=%b, expected disp=%h dp=%b en=%b run=%b",
                        $time, a.disp, a.dp, a.en, a.run, e.disp, e.dp, e.en, e.run);
         end
      end
   end

   initial begin : stimulus
      bit rs, rc, rl, rr;
      rs = 1'b0; rc = 1'b0; rl = 1'b0;
      btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0; rst_ = 1'b0;
      @(negedge clk_1kHz);

      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check_now("reset", 16'h0000, 4'b0111, 1'b0);
      idle(200);
      check_now("idle_200", 16'h0000, 4'b0111, 1'b0);

      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      run_until(150);  idle(1);
      check_now("run_01.50", 16'h0150, 4'b0111, 1'b1);
      run_until(1000); idle(1);
      check_now("run_10.00", 16'h1000, 4'b1111, 1'b1);

      run_until(1234);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      idle(500);
      check_now("lap_frozen", 16'h1234, 4'b1111, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      idle(1);
      check_now("lap_release", 16'h1284, 4'b1111, 1'b1);

      run_until(5999);
      run_until(0);
      idle(1);
      check_now("wrap_00.00", 16'h0000, 4'b0111, 1'b1);

      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      idle(1);
      check_now("clear", 16'h0000, 4'b0111, 1'b0);

      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      run_until(500);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      idle(300);
      check_now("stop_hold", 16'h0500, 4'b0111, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      idle(101);
      check_now("resume_05.10", 16'h0510, 4'b0111, 1'b1);

      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      idle(1);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      run_until(321);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      idle(1);
      check_now("clear_beats_start", 16'h0000, 4'b0111, 1'b0);

      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      idle(57);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check_now("reset_mid_run", 16'h0000, 4'b0111, 1'b0);

      // Start held through reset release: one event on the first post-reset cycle.
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (30) cyc(1'b1, 1'b0, 1'b0, 1'b1);
      check_now("held_through_reset", 16'h0002, 4'b0111, 1'b1);
      idle(1);

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0)  rs = ~rs;
         if ($urandom_range(0, 14) == 0)  rl = ~rl;
         if ($urandom_range(0, 149) == 0) rc = ~rc;
         rr = ($urandom_range(0, 499) != 0);
         cyc(rs, rc, rl, rr);
      end

      idle(1);
      @(posedge clk_1kHz);
      #2;
      if (sb_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
